// File: rtl/isa_pkg.sv
// Shared ISA constants: PC/LUT widths, branch condition codes, run-control states,
// the registered-flag bundle and the constant branch-target lookup table.
package isa_pkg;

   localparam int PC_W   = 12;
   localparam int LUT_AW = 4;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'b000,
      COND_EQ     = 3'b001,
      COND_NE     = 3'b010,
      COND_GT     = 3'b011,
      COND_LT     = 3'b100,
      COND_ZERO   = 3'b101,
      COND_CARRY  = 3'b110,
      COND_NEVER  = 3'b111
   } br_cond_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } run_state_t;

   typedef struct packed {
      logic equal;
      logic gt;
      logic lt;
      logic zero;
      logic carry;
   } flags_t;

   // Entry 15 first, entry 0 last; every entry is exactly PC_W bits.
   localparam logic [2**LUT_AW-1:0][PC_W-1:0] BR_LUT = {
      12'hFFE, 12'hC3D, 12'hBEE, 12'hA5A,
      12'h9AB, 12'h800, 12'h7FF, 12'h6D9,
      12'h5C2, 12'h400, 12'h347, 12'h2B0,
      12'h1F4, 12'h03A, 12'h025, 12'h010
   };

endpackage

// File: rtl/flag_reg.sv
// Five registered ALU flags (equal/gt/lt/zero/carry); one-cycle load latency.
// Synchronous clear takes priority over load; otherwise the flags hold.
module flag_reg
   import isa_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   clr,
   input  logic   ld,
   input  flags_t alu_flags,
   output flags_t flags
);

   flags_t flags_d, flags_q;

   always_comb begin
      flags_d = flags_q;
      if (clr) begin
         flags_d = '0;
      end else if (ld) begin
         flags_d = alu_flags;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: rtl/branch_flag_ctrl.sv
// Flag register, branch condition evaluation and run-control FSM feeding the PC.
// jump/target/run/pc_clr/done are combinational, so a branch costs no extra cycle.
module branch_flag_ctrl
   import isa_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt_instr,
   input  logic              flag_we,
   input  logic              equal,
   input  logic              gt,
   input  logic              lt,
   input  logic              zero,
   input  logic              c_o,
   input  logic              br_en,
   input  logic [2:0]        br_cond,
   input  logic [LUT_AW-1:0] lut_idx,
   output logic [PC_W-1:0]   target,
   output logic              jump,
   output logic              pc_clr,
   output logic              run,
   output logic              c_i,
   output logic              equalQ,
   output logic              gtQ,
   output logic              ltQ,
   output logic              zeroQ,
   output logic              done
);

   run_state_t state_d, state_q;
   flags_t     alu_flags;
   flags_t     flags;
   logic       cond_true;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_ARM;
         ST_ARM:  if (!start) state_d = ST_RUN;
         // A restart request outranks a halt decoded in the same cycle.
         ST_RUN: begin
            if (start) begin
               state_d = ST_ARM;
            end else if (halt_instr) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: if (start) state_d = ST_ARM;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign alu_flags = '{equal: equal, gt: gt, lt: lt, zero: zero, carry: c_o};

   flag_reg u_flag_reg (
      .clk       (clk),
      .reset     (reset),
      .clr       (state_q == ST_ARM),
      .ld        (flag_we && (state_q == ST_RUN)),
      .alu_flags (alu_flags),
      .flags     (flags)
   );

   // Conditions look only at registered flags, so a same-cycle flag write is not seen.
   always_comb begin
      cond_true = 1'b0;
      case (br_cond_t'(br_cond))
         COND_ALWAYS: cond_true = 1'b1;
         COND_EQ:     cond_true = flags.equal;
         COND_NE:     cond_true = !flags.equal;
         COND_GT:     cond_true = flags.gt;
         COND_LT:     cond_true = flags.lt;
         COND_ZERO:   cond_true = flags.zero;
         COND_CARRY:  cond_true = flags.carry;
         COND_NEVER:  cond_true = 1'b0;
         default:     cond_true = 1'b0;
      endcase
   end

   assign run    = (state_q == ST_RUN);
   assign pc_clr = (state_q == ST_ARM);
   assign done   = (state_q == ST_HALT);
   assign jump   = run && br_en && cond_true && !halt_instr;
   assign target = BR_LUT[lut_idx];

   assign equalQ = flags.equal;
   assign gtQ    = flags.gt;
   assign ltQ    = flags.lt;
   assign zeroQ  = flags.zero;
   assign c_i    = flags.carry;

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Directed vectors with hand-computed expectations; a queue-based scoreboard
// is filled by the stimulus process and drained by a negedge monitor.
module tb_branch_flag_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        halt_instr;
   logic        flag_we;
   logic        equal, gt, lt, zero, c_o;
   logic        br_en;
   logic [2:0]  br_cond;
   logic [3:0]  lut_idx;
   logic [11:0] target;
   logic        jump, pc_clr, run, c_i;
   logic        equalQ, gtQ, ltQ, zeroQ, done;

   typedef struct packed {
      logic [7:0]  id;
      logic        run;
      logic        pc_clr;
      logic        done;
      logic        jump;
      logic [11:0] target;
      logic [4:0]  flags;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   branch_flag_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .halt_instr (halt_instr),
      .flag_we    (flag_we),
      .equal      (equal),
      .gt         (gt),
      .lt         (lt),
      .zero       (zero),
      .c_o        (c_o),
      .br_en      (br_en),
      .br_cond    (br_cond),
      .lut_idx    (lut_idx),
      .target     (target),
      .jump       (jump),
      .pc_clr     (pc_clr),
      .run        (run),
      .c_i        (c_i),
      .equalQ     (equalQ),
      .gtQ        (gtQ),
      .ltQ        (ltQ),
      .zeroQ      (zeroQ),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // alu = {equal, gt, lt, zero, c_o}; ef = {equalQ, gtQ, ltQ, zeroQ, c_i}
   task automatic cyc(input logic [7:0] id, input logic rst, input logic st, input logic hlt,
                      input logic fwe, input logic [4:0] alu, input logic ben,
                      input logic [2:0] cond, input logic [3:0] idx,
                      input logic er, input logic ep, input logic ed, input logic ej,
                      input logic [11:0] et, input logic [4:0] ef);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = rst;
      start      = st;
      halt_instr = hlt;
      flag_we    = fwe;
      {equal, gt, lt, zero, c_o} = alu;
      br_en      = ben;
      br_cond    = cond;
      lut_idx    = idx;
      e.id = id; e.run = er; e.pc_clr = ep; e.done = ed; e.jump = ej;
      e.target = et; e.flags = ef;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t act;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = '{id: e.id, run: run, pc_clr: pc_clr, done: done, jump: jump,
                    target: target, flags: {equalQ, gtQ, ltQ, zeroQ, c_i}};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL vec%0d got run=%b pc_clr=%b done=%b jump=%b target=%h flags=%b want run=%b pc_clr=%b done=%b jump=%b target=%h flags=%b",
                        e.id, act.run, act.pc_clr, act.done, act.jump, act.target, act.flags,
                        e.run, e.pc_clr, e.done, e.jump, e.target, e.flags);
            end
         end
      end
   end

   initial begin : stim
      reset = 1'b0; start = 1'b0; halt_instr = 1'b0; flag_we = 1'b0;
      {equal, gt, lt, zero, c_o} = 5'b0;
      br_en = 1'b0; br_cond = 3'd0; lut_idx = 4'd0;

      //   id rst st hlt fwe alu      ben cnd idx   run clr dn jmp target   flags
      cyc( 0, 0, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd3,  0, 0, 0, 0, 12'h1F4, 5'b00000);
      cyc( 1, 1, 1, 0, 0, 5'b00000, 0, 3'd0, 4'd0,  0, 0, 0, 0, 12'h010, 5'b00000);
      cyc( 2, 1, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd5,  0, 1, 0, 0, 12'h347, 5'b00000);
      cyc( 3, 1, 0, 0, 1, 5'b10000, 0, 3'd0, 4'd3,  1, 0, 0, 0, 12'h1F4, 5'b00000);
      cyc( 4, 1, 0, 0, 0, 5'b00000, 1, 3'd1, 4'd3,  1, 0, 0, 1, 12'h1F4, 5'b10000);
      cyc( 5, 1, 0, 0, 0, 5'b00000, 1, 3'd2, 4'd3,  1, 0, 0, 0, 12'h1F4, 5'b10000);
      cyc( 6, 1, 0, 0, 1, 5'b10001, 1, 3'd6, 4'd7,  1, 0, 0, 0, 12'h5C2, 5'b10000);
      cyc( 7, 1, 0, 0, 0, 5'b00000, 1, 3'd6, 4'd7,  1, 0, 0, 1, 12'h5C2, 5'b10001);
      cyc( 8, 1, 0, 0, 1, 5'b01010, 1, 3'd0, 4'd9,  1, 0, 0, 1, 12'h7FF, 5'b10001);
      cyc( 9, 1, 0, 0, 0, 5'b00000, 1, 3'd3, 4'd2,  1, 0, 0, 1, 12'h03A, 5'b01010);
      cyc(10, 1, 0, 0, 0, 5'b00000, 1, 3'd4, 4'd15, 1, 0, 0, 0, 12'hFFE, 5'b01010);
      cyc(11, 1, 0, 0, 0, 5'b00000, 1, 3'd5, 4'd12, 1, 0, 0, 1, 12'hA5A, 5'b01010);
      cyc(12, 1, 0, 0, 0, 5'b00000, 1, 3'd7, 4'd4,  1, 0, 0, 0, 12'h2B0, 5'b01010);
      cyc(13, 1, 0, 1, 0, 5'b00000, 1, 3'd0, 4'd6,  1, 0, 0, 0, 12'h400, 5'b01010);
      cyc(14, 1, 0, 0, 1, 5'b10101, 1, 3'd0, 4'd1,  0, 0, 1, 0, 12'h025, 5'b01010);
      cyc(15, 1, 1, 0, 0, 5'b00000, 0, 3'd0, 4'd8,  0, 0, 1, 0, 12'h6D9, 5'b01010);
      cyc(16, 1, 1, 0, 0, 5'b00000, 0, 3'd0, 4'd10, 0, 1, 0, 0, 12'h800, 5'b01010);
      cyc(17, 1, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd11, 0, 1, 0, 0, 12'h9AB, 5'b00000);
      cyc(18, 1, 0, 0, 1, 5'b00010, 0, 3'd0, 4'd13, 1, 0, 0, 0, 12'hBEE, 5'b00000);
      cyc(19, 1, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd14, 1, 0, 0, 0, 12'hC3D, 5'b00010);
      // Reset dropped between edges: outputs must clear before the next rising edge.
      cyc(20, 0, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd14, 0, 0, 0, 0, 12'hC3D, 5'b00000);
      cyc(21, 1, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd0,  0, 0, 0, 0, 12'h010, 5'b00000);
      cyc(22, 1, 1, 0, 0, 5'b00000, 0, 3'd0, 4'd0,  0, 0, 0, 0, 12'h010, 5'b00000);
      cyc(23, 1, 0, 0, 0, 5'b00000, 0, 3'd0, 4'd0,  0, 1, 0, 0, 12'h010, 5'b00000);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
